// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free frame latching and anode dead-time.
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [DW-1:0]         pend_reg, pend_next;
  logic                  pend_valid_reg, pend_valid_next;
  logic [DW-1:0]         active_reg, active_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  fd_reg, fd_next;
  logic                  slot_end, wrap;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] sup;
  logic [3:0]            cur_nib;
  logic [6:0]            dec;
  logic                  dig_off;

  always_comb begin
    slot_end        = en && (cnt_reg == CNT_LAST);
    wrap            = slot_end && (idx_reg == IDX_LAST);
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    if (en) begin
      if (slot_end) begin
        cnt_next = '0;
        idx_next = wrap ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    // A load on the wrap edge still hands the older pending value to active first.
    active_next     = (wrap && pend_valid_reg) ? pend_reg : active_reg;
    pend_next       = load ? digits_in : pend_reg;
    pend_valid_next = load || (pend_valid_reg && !wrap);
    fd_next         = wrap;
  end

  // Outputs are decoded from next-state so they move on the same edge as cnt/idx.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]    = active_next[4*gi +: 4];
    assign onehot[gi] = (idx_next == IW'(gi));
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  always_comb begin
    logic run;
    sup = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run    = run && (nib[i] == 4'd0);
      sup[i] = run;
    end
  end
`else
  assign sup = '0;
`endif

  always_comb begin
    cur_nib = nib[idx_next];
    dig_off = blank_mask[idx_next] || sup[idx_next];
    case (cur_nib)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = SEG_OFF;
    endcase
    seg_next = SEG_OFF;
    an_next  = '1;
    if (en) begin
      seg_next = dig_off ? SEG_OFF : dec;
      if (!dig_off && (cnt_next >= DEAD)) an_next = ~onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      active_reg     <= '0;
      seg_reg        <= SEG_OFF;
      an_reg         <= '1;
      fd_reg         <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      active_reg     <= active_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      fd_reg         <= fd_next;
    end
  end

  assign seg_out    = seg_reg;
  assign an_out     = an_reg;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed table-driven bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1).
// Honours SEG_SCAN_LZ_SUPPRESS_EN when the design is built with it.
module tb_seg_scan_ctrl;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111,
                         S8 = 7'b0000000, S9 = 7'b0000100, BL = 7'b1111111;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  bm;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, en, load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .blank_mask(blank_mask), .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  task automatic add_vec(input logic e, input logic l, input logic [15:0] d, input logic [3:0] bm,
                         input logic [6:0] seg, input logic [3:0] an, input logic fd);
    vec_t v;
    v.en = e; v.ld = l; v.d = d; v.bm = bm; v.seg = seg; v.an = an; v.fd = fd;
    tbl.push_back(v);
  endtask

  // One 4-cycle digit slot: dead cycle first, then the lit anode pattern.
  task automatic add_slot(input logic [6:0] seg, input logic [3:0] an, input logic fd,
                          input int ld_at, input logic [15:0] ld_d, input logic [3:0] bm);
    for (int c = 0; c < 4; c++)
      add_vec(1'b1, c == ld_at, ld_d, bm, seg, (c == 0) ? 4'b1111 : an, (c == 0) ? fd : 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fd_seen;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; blank_mask = '0;

    // Frame 1 shows zeros while 1234 waits in pending.
    add_vec(1, 0, 16'h0000, 4'b0000, S0, 4'b1110, 0);
    add_vec(1, 1, 16'h1234, 4'b0000, S0, 4'b1110, 0);
    add_vec(1, 0, 16'h0000, 4'b0000, S0, 4'b1110, 0);
    add_slot(LZ ? BL : S0, LZ ? 4'b1111 : 4'b1101, 0, -1, 16'h0, 4'b0);
    add_slot(LZ ? BL : S0, LZ ? 4'b1111 : 4'b1011, 0, -1, 16'h0, 4'b0);
    add_slot(LZ ? BL : S0, LZ ? 4'b1111 : 4'b0111, 0, -1, 16'h0, 4'b0);
    // 1234 shown; two loads, last one wins.
    add_slot(S4, 4'b1110, 1, -1, 16'h0000, 4'b0);
    add_slot(S3, 4'b1101, 0,  1, 16'h1111, 4'b0);
    add_slot(S2, 4'b1011, 0,  2, 16'h9999, 4'b0);
    add_slot(S1, 4'b0111, 0, -1, 16'h0000, 4'b0);
    // 9999 shown; 5678 loaded, then 2222 loaded on the boundary edge.
    add_slot(S9, 4'b1110, 1, -1, 16'h0000, 4'b0);
    add_slot(S9, 4'b1101, 0,  0, 16'h5678, 4'b0);
    add_slot(S9, 4'b1011, 0, -1, 16'h0000, 4'b0);
    add_slot(S9, 4'b0111, 0, -1, 16'h0000, 4'b0);
    add_slot(S8, 4'b1110, 1,  0, 16'h2222, 4'b0);
    add_slot(S7, 4'b1101, 0, -1, 16'h0000, 4'b0);
    add_slot(S6, 4'b1011, 0, -1, 16'h0000, 4'b0);
    add_slot(S5, 4'b0111, 0, -1, 16'h0000, 4'b0);
    add_slot(S2, 4'b1110, 1, -1, 16'h0000, 4'b0);
    add_slot(S2, 4'b1101, 0,  0, 16'hFA05, 4'b0);
    add_slot(S2, 4'b1011, 0, -1, 16'h0000, 4'b0);
    add_slot(S2, 4'b0111, 0, -1, 16'h0000, 4'b0);
    // FA05 with digit 1 masked; A and F decode blank with anode lit.
    add_slot(S5, 4'b1110, 1, -1, 16'h0000, 4'b0010);
    add_slot(BL, 4'b1111, 0, -1, 16'h0000, 4'b0010);
    add_slot(BL, 4'b1011, 0, -1, 16'h0000, 4'b0010);
    add_slot(BL, 4'b0111, 0, -1, 16'h0000, 4'b0010);
    // Mask released; drop en at cnt=2 idx=2 for 10 cycles, loading 4444 meanwhile.
    add_slot(S5, 4'b1110, 1, -1, 16'h0000, 4'b0);
    add_slot(S0, 4'b1101, 0, -1, 16'h0000, 4'b0);
    add_vec(1, 0, 16'h0000, 4'b0, BL, 4'b1111, 0);
    add_vec(1, 0, 16'h0000, 4'b0, BL, 4'b1011, 0);
    add_vec(1, 0, 16'h0000, 4'b0, BL, 4'b1011, 0);
    for (int k = 0; k < 10; k++) add_vec(0, k == 0, 16'h4444, 4'b0, BL, 4'b1111, 0);
    add_vec(1, 0, 16'h0000, 4'b0, BL, 4'b1011, 0);
    add_slot(BL, 4'b0111, 0, -1, 16'h0000, 4'b0);
    add_slot(S4, 4'b1110, 1, -1, 16'h0000, 4'b0);

    tick;
    tick;
    chk("reset_seg", 0, 32'(seg_out), 32'(BL));
    chk("reset_an", 0, 32'(an_out), 32'hF);
    chk("reset_fd", 0, 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; load = tbl[i].ld; digits_in = tbl[i].d; blank_mask = tbl[i].bm;
      tick;
      chk("seg", i + 1, 32'(seg_out), 32'(tbl[i].seg));
      chk("an", i + 1, 32'(an_out), 32'(tbl[i].an));
      chk("frame_done", i + 1, 32'(frame_done), 32'(tbl[i].fd));
      $display("vec %0d: en=%b ld=%b d=%h bm=%b -> seg=%b an=%b fd=%b",
               i + 1, tbl[i].en, tbl[i].ld, tbl[i].d, tbl[i].bm, seg_out, an_out, frame_done);
    end

    // Reset mid-slot with a pending 7777: pending must be discarded.
    en = 1'b1; load = 1'b1; digits_in = 16'h7777;
    tick;
    load = 1'b0; rst_n = 1'b0;
    tick;
    chk("midrst_seg", 0, 32'(seg_out), 32'(BL));
    chk("midrst_an", 0, 32'(an_out), 32'hF);
    chk("midrst_fd", 0, 32'(frame_done), 32'h0);
    $display("mid-frame reset: seg=%b an=%b fd=%b", seg_out, an_out, frame_done);
    rst_n = 1'b1;
    tick;
    chk("postrst_seg", 1, 32'(seg_out), 32'(S0));
    chk("postrst_an", 1, 32'(an_out), 32'hE);
    fd_seen = 0;
    for (int k = 2; k <= 16; k++) begin
      tick;
      if (frame_done) fd_seen++;
    end
    chk("postrst_fd_edge16", 16, 32'(frame_done), 32'h1);
    chk("postrst_fd_count", 16, 32'(fd_seen), 32'h1);
    chk("postrst_seg_edge16", 16, 32'(seg_out), 32'(S0));
    $display("post-reset frame: fd_count=%0d seg=%b an=%b", fd_seen, seg_out, an_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
